// File: rtl/round_sequencer_pkg.sv
// Shared types and encodings for the reaction-game round sequencer.
// States, display-mux codes and stopwatch control words.
package round_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_HOLDOFF,
    S_PLAY,
    S_RESULT,
    S_DONE
  } state_e;

  localparam logic [1:0] DISP_TIME = 2'd0;
  localparam logic [1:0] DISP_GOAL = 2'd1;
  localparam logic [1:0] DISP_LOSS = 2'd2;
  localparam logic [1:0] DISP_SUM  = 2'd3;

  localparam logic [1:0] TC_CLR  = 2'b01;
  localparam logic [1:0] TC_RUN  = 2'b10;
  localparam logic [1:0] TC_HOLD = 2'b00;

  localparam int RELEASE_CODE_DEF = 21;

endpackage

// File: rtl/round_sequencer_key_event_detect.sv
// Key-change detector: flags any change of the keyboard-wrapper code
// and whether the new code is the key-up marker.
module key_event_detect #(
  parameter int RELEASE_CODE = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] letter_i,
  output logic       evt_o,
  output logic       evt_is_release_o
);

  localparam logic [4:0] RC = 5'(RELEASE_CODE);

  logic [4:0] last_q;

  always_ff @(posedge clk) begin
    if (rst) last_q <= RC;
    else     last_q <= letter_i;
  end

  assign evt_o            = (letter_i != last_q);
  assign evt_is_release_o = evt_o && (letter_i == RC);

endmodule

// File: rtl/round_sequencer.sv
// Match controller for the keyboard reaction game.
// Optional TIMEOUT_EN: a round expires as a miss at LIMIT_S seconds.
module round_sequencer
  import round_sequencer_pkg::*;
#(
  parameter int NUM_ROUNDS     = 5,
  parameter int RELEASE_CODE   = RELEASE_CODE_DEF,
  parameter int LETTER_COUNT   = 26,
  parameter int HOLDOFF_CYCLES = 8000000
`ifdef TIMEOUT_EN
  ,
  parameter int LIMIT_S        = 9
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  letter,
  input  logic [4:0]  rand_in,
  input  logic [3:0]  timer_s,
  input  logic [3:0]  timer_ms,
  input  logic [3:0]  timer_mms,
  output logic [1:0]  timer_ctrl,
  output logic [4:0]  goal_letter,
  output logic [1:0]  disp_sel,
  output logic [3:0]  round_idx,
  output logic [3:0]  hit_count,
  output logic [3:0]  miss_count,
  output logic [11:0] best_time,
  output logic        best_valid,
  output logic        done
);

  localparam int CW = (HOLDOFF_CYCLES > 1) ?
                      $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLDOFF_CYCLES - 1);
  localparam logic [4:0] RC = 5'(RELEASE_CODE);
  localparam logic [4:0] LC = 5'(LETTER_COUNT);
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

  state_e        state_q, state_d;
  state_e        target_q, target_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_hit_q, last_hit_d;
  logic [1:0]    tc_q, tc_d;
  logic [4:0]    goal_q, goal_d;
  logic [1:0]    disp_q, disp_d;
  logic [3:0]    round_q, round_d;
  logic [3:0]    hit_q, hit_d;
  logic [3:0]    miss_q, miss_d;
  logic [11:0]   best_q, best_d;
  logic          bv_q, bv_d;
  logic          done_q, done_d;

  logic        evt, evt_rel, key_nr, timeout;
  logic [11:0] now_t;

  key_event_detect #(
    .RELEASE_CODE(RELEASE_CODE)
  ) u_ked (
    .clk              (clk),
    .rst              (rst),
    .letter_i         (letter),
    .evt_o            (evt),
    .evt_is_release_o (evt_rel)
  );

  assign key_nr = evt && !evt_rel;
  assign now_t  = {timer_s, timer_ms, timer_mms};

`ifdef TIMEOUT_EN
  localparam logic [3:0] LIM = 4'(LIMIT_S);
  assign timeout = (timer_s == LIM);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    cnt_d      = cnt_q;
    last_hit_d = last_hit_q;
    goal_d     = goal_q;
    round_d    = round_q;
    hit_d      = hit_q;
    miss_d     = miss_q;
    best_d     = best_q;
    bv_d       = bv_q;
    done_d     = done_q;
    tc_d       = TC_CLR;
    disp_d     = DISP_TIME;

    unique case (state_q)
      S_IDLE: begin
        if (evt_rel) begin
          hit_d   = '0;
          miss_d  = '0;
          best_d  = 12'hFFF;
          bv_d    = 1'b0;
          done_d  = 1'b0;
          round_d = '0;
          state_d = S_PICK;
        end
      end
      S_PICK: begin
        if (rand_in < LC && rand_in != RC) begin
          goal_d   = rand_in;
          target_d = S_PLAY;
          state_d  = S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        if (key_nr || cnt_q == CNT_LAST) begin
          state_d = target_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PLAY: begin
        if (key_nr || timeout) begin
          target_d = S_RESULT;
          state_d  = S_HOLDOFF;
          // A timeout is scored exactly like a wrong key.
          if (key_nr && letter == goal_q) begin
            last_hit_d = 1'b1;
            hit_d      = hit_q + 4'd1;
            if (!bv_q || now_t < best_q) begin
              best_d = now_t;
              bv_d   = 1'b1;
            end
          end else begin
            last_hit_d = 1'b0;
            miss_d     = miss_q + 4'd1;
          end
        end
      end
      S_RESULT: begin
        if (key_nr) begin
          if (round_q == LAST_ROUND) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            round_d = round_q + 4'd1;
            state_d = S_PICK;
          end
        end
      end
      S_DONE: begin
        if (key_nr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    unique case (state_d)
      S_IDLE:    begin tc_d = TC_CLR;  disp_d = DISP_TIME; end
      S_PICK:    begin tc_d = TC_CLR;  disp_d = DISP_GOAL; end
      S_PLAY:    begin tc_d = TC_RUN;  disp_d = DISP_GOAL; end
      S_DONE:    begin tc_d = TC_CLR;  disp_d = DISP_SUM;  end
      S_RESULT: begin
        tc_d   = TC_HOLD;
        disp_d = last_hit_d ? DISP_TIME : DISP_LOSS;
      end
      S_HOLDOFF: begin
        if (target_d == S_PLAY) begin
          tc_d   = TC_CLR;
          disp_d = DISP_GOAL;
        end else begin
          tc_d   = TC_HOLD;
          disp_d = last_hit_d ? DISP_TIME : DISP_LOSS;
        end
      end
      default: begin tc_d = TC_CLR; disp_d = DISP_TIME; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      target_q   <= S_PLAY;
      cnt_q      <= '0;
      last_hit_q <= 1'b0;
      tc_q       <= TC_CLR;
      goal_q     <= '0;
      disp_q     <= DISP_TIME;
      round_q    <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
      best_q     <= 12'hFFF;
      bv_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      cnt_q      <= cnt_d;
      last_hit_q <= last_hit_d;
      tc_q       <= tc_d;
      goal_q     <= goal_d;
      disp_q     <= disp_d;
      round_q    <= round_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      best_q     <= best_d;
      bv_q       <= bv_d;
      done_q     <= done_d;
    end
  end

  assign timer_ctrl  = tc_q;
  assign goal_letter = goal_q;
  assign disp_sel    = disp_q;
  assign round_idx   = round_q;
  assign hit_count   = hit_q;
  assign miss_count  = miss_q;
  assign best_time   = best_q;
  assign best_valid  = bv_q;
  assign done        = done_q;

endmodule
